// File: rtl/fwd_pkg.sv
// Shared constants and width helpers for the operand-forwarding / scoreboard block.
package fwd_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int FWD_SEL_RF = 0;

   function automatic int fwd_sel_width(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int sb_cnt_width(input int max_outstanding);
      return $clog2(max_outstanding + 1);
   endfunction

endpackage

// File: rtl/fwd_scoreboard.sv
// Register scoreboard: pending bits for long-latency writes, outstanding-op counter,
// and issue acceptance (capacity + WAW blocking).
module fwd_scoreboard
   import fwd_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic                  done_valid,
   input  logic [REG_ADDR_W-1:0] done_rd,
   output logic                  issue_ready,
   output logic [NUM_REGS-1:0]   pending
);

   localparam int CNT_W = sb_cnt_width(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [CNT_W-1:0]    count_q;
   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_nxt;
   logic                issue_acc;
   logic                done_err;
   logic                done_acc;
   logic                cnt_inc;
   logic                cnt_dec;

   assign issue_ready = (count_q < CNT_MAX) &&
                        !((issue_rd != '0) && pending_q[issue_rd]);
   assign issue_acc   = issue_valid && issue_ready;

   // A completion for a non-pending nonzero register is a protocol error and is ignored.
   assign done_err = (done_rd != '0) && !pending_q[done_rd];
   assign done_acc = done_valid && !done_err;

   assign cnt_inc = issue_acc;
   assign cnt_dec = done_acc && (count_q != '0);

   always_comb begin
      pending_nxt = pending_q;
      if (issue_acc && (issue_rd != '0))
         pending_nxt[issue_rd] = 1'b1;
      if (done_acc && (done_rd != '0))
         pending_nxt[done_rd] = 1'b0;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         count_q   <= '0;
      end else begin
         pending_q <= pending_nxt;
         case ({cnt_inc, cnt_dec})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/forwarding_scoreboard_unit.sv
// EX-stage operand bypass select with youngest-stage priority, load-use and scoreboard stall.
// Optional stall-cycle performance counter built when FWD_SB_PERF_EN is defined.
module forwarding_scoreboard_unit
   import fwd_pkg::*;
#(
   parameter int NUM_SRC         = 2,
   parameter int NUM_FWD         = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int SELW            = fwd_sel_width(NUM_FWD)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_SRC*5-1:0]    rs_ex,
   input  logic [NUM_SRC-1:0]      rs_valid_ex,
   input  logic [NUM_FWD*5-1:0]    fwd_rd,
   input  logic [NUM_FWD-1:0]      fwd_we,
   input  logic [NUM_FWD-1:0]      fwd_ready,
   input  logic                    issue_valid,
   input  logic [4:0]              issue_rd,
   output logic                    issue_ready,
   input  logic                    done_valid,
   input  logic [4:0]              done_rd,
   output logic [NUM_SRC*SELW-1:0] fwd_sel,
   output logic                    stall_ex,
   output logic [31:0]             sb_pending,
   output logic [31:0]             stall_cycles
);

   logic [NUM_SRC-1:0] load_use;
   logic [NUM_SRC-1:0] sb_hit;

   fwd_scoreboard #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
   ) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .issue_valid(issue_valid),
      .issue_rd   (issue_rd),
      .done_valid (done_valid),
      .done_rd    (done_rd),
      .issue_ready(issue_ready),
      .pending    (sb_pending)
   );

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_ADDR_W-1:0] rs;
      logic [SELW-1:0]       sel;
      logic                  sel_ready;

      assign rs = rs_ex[gi*REG_ADDR_W +: REG_ADDR_W];

      // Walk oldest to youngest so the youngest matching stage overwrites older ones.
      always_comb begin
         sel       = SELW'(FWD_SEL_RF);
         sel_ready = 1'b1;
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (rs_valid_ex[gi] && fwd_we[k] &&
                (fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] != '0) &&
                (fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] == rs)) begin
               sel       = SELW'(k + 1);
               sel_ready = fwd_ready[k];
            end
         end
      end

      assign fwd_sel[gi*SELW +: SELW] = sel;
      assign load_use[gi] = (sel != SELW'(FWD_SEL_RF)) && !sel_ready;
      assign sb_hit[gi]   = rs_valid_ex[gi] && (rs != '0) && sb_pending[rs];
   end

   assign stall_ex = (|load_use) || (|sb_hit);

`ifdef FWD_SB_PERF_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt_q <= '0;
      else if (stall_ex)
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign stall_cycles = stall_cnt_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: doc/forwarding_scoreboard_unit.md
Name: forwarding_scoreboard_unit

Overview:
Next-generation operand bypass and hazard block for the EX stage.
- Generalises MEM/WB forwarding to NUM_SRC source operands and NUM_FWD bypass stages, with youngest-stage priority.
- Adds a load-use stall driven by per-stage data-ready flags.
- Adds a 32-entry register scoreboard that tracks outstanding long-latency writes (mul/div, miss loads), with an outstanding-op counter and WAW issue blocking.
- Sits between the decode/EX pipeline registers and the ALU operand muxes; drives the EX stall to the hazard/stall controller.

Parameters:
NUM_SRC, 2, number of source operands checked per cycle (rs1, rs2, ...)
NUM_FWD, 2, number of bypass stages; index 0 = youngest (MEM), 1 = WB, ...
MAX_OUTSTANDING, 4, maximum long-latency ops in flight (1..31)
SELW, $clog2(NUM_FWD+1), width of each forward select field (derived, do not override)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
rs_ex  in  NUM_SRC*5  source register addresses in EX; operand i at [5i+4:5i]
rs_valid_ex  in  NUM_SRC  operand i is actually read by the EX instruction
fwd_rd  in  NUM_FWD*5  destination address held in bypass stage k
fwd_we  in  NUM_FWD  stage k will write fwd_rd[k]
fwd_ready  in  NUM_FWD  stage k's result value is available this cycle (0 for a load still in MEM)
issue_valid  in  1  EX is handing a long-latency op to a multicycle unit
issue_rd  in  5  destination of that op
issue_ready  out  1  long-latency issue accepted this cycle
done_valid  in  1  multicycle unit writes its result to the register file this cycle
done_rd  in  5  destination of that completion
fwd_sel  out  NUM_SRC*SELW  per operand: 0 = register file, k+1 = bypass stage k
stall_ex  out  1  hold EX and earlier stages; insert bubble into MEM
sb_pending  out  32  scoreboard pending bits (debug/visibility)
stall_cycles  out  32  stall cycle counter (see Optional Feature)

Behaviour:
- Match for operand i at stage k: rs_valid_ex[i] && fwd_we[k] && fwd_rd[k] != 0 && fwd_rd[k] == rs[i].
- fwd_sel[i] = k+1 for the lowest matching k; 0 if there is no match. The output is combinational (zero latency).
- Load-use: if the selected stage has fwd_ready[k] = 0, stall_ex = 1. fwd_sel still shows that stage.
- Scoreboard hit: rs_valid_ex[i] && rs[i] != 0 && pending[rs[i]] gives stall_ex = 1, regardless of any bypass match.
- stall_ex = OR of all load-use and scoreboard conditions over all operands.
- issue_ready = (count < MAX_OUTSTANDING) && !(issue_rd != 0 && pending[issue_rd]).
  - Issuing to a pending rd is blocked (WAW); no same-cycle bypass of done.
- Accepted issue (issue_valid && issue_ready):
  - Next edge: pending[issue_rd] <= 1 unless issue_rd = 0.
  - count increments, including for rd 0. The unit still signals done_valid with done_rd = 0.
- done_valid:
  - Next edge: pending[done_rd] <= 0 and count decrements.
  - If done_rd != 0 and pending[done_rd] is already 0: protocol error. Bits and count are left unchanged.
- Accepted issue and done in the same cycle: count is unchanged. The two bit updates apply independently; same-rd overlap cannot occur because issue is blocked when that rd is pending.
- pending[0] is constant 0. The count never wraps: issue is blocked at MAX, and there is no decrement at 0.
- Reset (async assert, sync to clk on deassert): pending = 0, count = 0, stall_cycles = 0.
  - Combinational outputs then depend only on inputs: fwd_sel per match rules, issue_ready = 1.
  - Reset mid-operation discards all in-flight tracking; the surrounding pipeline is reset together with this block.

Optional Feature:
Macro FWD_SB_PERF_EN.
- Defined: stall_cycles increments every clock with stall_ex = 1 and wraps at 2^32. It resets to 0.
- Undefined: the counter is not built and stall_cycles is tied to 0. Port list is identical in both builds.

Decomposition:
- Package fwd_pkg:
  - REG_ADDR_W = 5, NUM_REGS = 32, FWD_SEL_RF = 0.
  - Function fwd_sel_width(n) returning $clog2(n+1).
  - Scoreboard counter width function $clog2(MAX_OUTSTANDING+1).
- Sub-module fwd_scoreboard:
  - Holds the pending bits, the outstanding counter, and the issue_ready/clear logic.
  - Bypass priority muxing and stall OR stay in the top module.

Test Plan:
- MEM stage rd=5 we=1 ready=1, WB stage rd=5 we=1, rs1=5 -> fwd_sel[0]=1 (MEM wins); rs2=0 matched by a stage with rd=0 -> fwd_sel[1]=0.
- Load in MEM, rd=7, fwd_ready[0]=0; rs2=7 -> stall_ex=1 for 1 cycle. Next cycle: load in WB with ready=1 -> fwd_sel[1]=2, stall_ex=0.
- Issue long op rd=9 -> sb_pending[9]=1 after the edge. rs1=9 -> stall_ex=1 until done_rd=9; stall_ex=0 the cycle after done.
- MAX_OUTSTANDING=4, issue rd=1..4 -> issue_ready=0 on the 5th. Issue rd=6 with done rd=1 in the same cycle -> issue_ready remains 0 (count still 4); next cycle issue accepted, count stays 4.
- Pending rd=3, issue_rd=3 -> issue_ready=0 (WAW). Assert rst_n=0 mid-flight -> sb_pending=0 immediately, issue_ready=1.
- With FWD_SB_PERF_EN: 3 scoreboard stall cycles + 1 load-use stall cycle -> stall_cycles=4. Without the macro -> stall_cycles=0.
